unidad_control_multiciclo: RTL and testbench

Multicycle control FSM for the RV32I core subset. It sequences fetch, decode, execute, memory and writeback over the shared datapath. It drives the immediate-extension select (including the 12→32 zero-extend path) and the ALU, register-file, PC and memory controls, and handshakes with a single shared instruction/data memory port. It also counts retired instructions.

---
 rtl/riscv_ctrl_pkg.sv | 51 +++++
 rtl/opcode_decoder.sv | 62 ++++++
 rtl/unidad_control_multiciclo.sv | 185 ++++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states, opcodes
// and the select/operation codes driven onto the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_EXEC_I,
      ST_ADDR,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_WB_ALU,
      ST_WB_MEM,
      ST_BRANCH,
      ST_JAL,
      ST_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] IMM_ZERO12 = 3'd0;
   localparam logic [2:0] IMM_SIGN_I = 3'd1;
   localparam logic [2:0] IMM_S      = 3'd2;
   localparam logic [2:0] IMM_B      = 3'd3;
   localparam logic [2:0] IMM_U      = 3'd4;
   localparam logic [2:0] IMM_J      = 3'd5;

   localparam logic [1:0] SRC_A_PC   = 2'd0;
   localparam logic [1:0] SRC_A_RS1  = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] WB_ALU_RES  = 2'd0;
   localparam logic [1:0] WB_MEM_DATA = 2'd1;
   localparam logic [1:0] WB_PC4      = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction classifier: picks the post-DECODE state, the
// memory state after ADDR, the immediate format and instruction legality.
module opcode_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output state_t     decode_next,
   output state_t     mem_next,
   output logic       legal,
   output logic       branch_on_zero,
   output logic [2:0] imm_kind,
   output logic [1:0] exec_src_a
);

   logic is_shift;
   logic branch_ok;

   assign is_shift       = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign branch_ok      = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign branch_on_zero = (funct3 == 3'b000);
   assign exec_src_a     = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_RS1;

   always_comb begin
      decode_next = ST_TRAP;
      mem_next    = ST_MEM_RD;
      legal       = 1'b1;
      imm_kind    = IMM_ZERO12;
      case (opcode)
         OP_R: decode_next = ST_EXEC_R;
         OP_IMM: begin
            decode_next = ST_EXEC_I;
            // shift amounts only use imm[4:0], so skip sign extension
            imm_kind    = is_shift ? IMM_ZERO12 : IMM_SIGN_I;
         end
         OP_LUI: begin
            decode_next = ST_EXEC_I;
            imm_kind    = IMM_U;
         end
         OP_LOAD: begin
            decode_next = ST_ADDR;
            imm_kind    = IMM_SIGN_I;
         end
         OP_STORE: begin
            decode_next = ST_ADDR;
            mem_next    = ST_MEM_WR;
            imm_kind    = IMM_S;
         end
         OP_BRANCH: begin
            decode_next = ST_BRANCH;
            legal       = branch_ok;
            imm_kind    = IMM_B;
         end
         OP_JAL: begin
            decode_next = ST_JAL;
            imm_kind    = IMM_J;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle RV32I control FSM: sequences the shared datapath and memory port,
// and counts retired instructions.
module unidad_control_multiciclo
   import riscv_ctrl_pkg::*;
#(
   parameter int IMM_SEL_W = 3
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 addr_sel,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 pc_src,
   output logic                 rf_we,
   output logic [1:0]           wb_sel,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 illegal,
   output logic [31:0]          instret
);

   state_t      state_reg, state_next;
   logic [31:0] instret_reg, instret_next;
   logic        retire;

   state_t      decode_next, mem_next;
   logic        legal, branch_on_zero;
   logic [2:0]  imm_kind;
   logic [1:0]  exec_src_a;

   logic        mem_req_raw, mem_we_raw, addr_sel_raw, ir_we_raw;
   logic        pc_we_raw, pc_src_raw, rf_we_raw, illegal_raw;
   logic [1:0]  wb_sel_raw, src_a_raw, src_b_raw, alu_op_raw;
   logic [2:0]  imm_raw;

   // funct7 bit 30 only matters to the ALU's funct decode, not to sequencing
   logic unused_funct7b5;
   assign unused_funct7b5 = funct7b5;

   opcode_decoder u_dec (
      .opcode         (opcode),
      .funct3         (funct3),
      .decode_next    (decode_next),
      .mem_next       (mem_next),
      .legal          (legal),
      .branch_on_zero (branch_on_zero),
      .imm_kind       (imm_kind),
      .exec_src_a     (exec_src_a)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_FETCH;
         instret_reg <= '0;
      end else begin
         state_reg   <= state_next;
         instret_reg <= instret_next;
      end
   end

   assign instret_next = instret_reg + 32'(retire);

   always_comb begin
      state_next   = state_reg;
      retire       = 1'b0;
      mem_req_raw  = 1'b0;
      mem_we_raw   = 1'b0;
      addr_sel_raw = 1'b0;
      ir_we_raw    = 1'b0;
      pc_we_raw    = 1'b0;
      pc_src_raw   = 1'b0;
      rf_we_raw    = 1'b0;
      illegal_raw  = 1'b0;
      wb_sel_raw   = WB_ALU_RES;
      src_a_raw    = SRC_A_PC;
      src_b_raw    = SRC_B_RS2;
      alu_op_raw   = ALU_ADD;
      imm_raw      = IMM_ZERO12;
      case (state_reg)
         ST_FETCH: begin
            mem_req_raw = 1'b1;
            if (mem_ready) begin
               ir_we_raw  = 1'b1;
               pc_we_raw  = 1'b1;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // branch/jump target PC+imm lands in the ALU result register
            src_b_raw  = SRC_B_IMM;
            imm_raw    = (opcode == OP_JAL) ? IMM_J : IMM_B;
            state_next = decode_next;
         end
         ST_EXEC_R: begin
            src_a_raw  = SRC_A_RS1;
            alu_op_raw = ALU_FUNCT;
            state_next = ST_WB_ALU;
         end
         ST_EXEC_I: begin
            src_a_raw  = exec_src_a;
            src_b_raw  = SRC_B_IMM;
            alu_op_raw = ALU_FUNCT;
            imm_raw    = imm_kind;
            state_next = ST_WB_ALU;
         end
         ST_ADDR: begin
            src_a_raw  = SRC_A_RS1;
            src_b_raw  = SRC_B_IMM;
            imm_raw    = imm_kind;
            state_next = mem_next;
         end
         ST_MEM_RD: begin
            mem_req_raw  = 1'b1;
            addr_sel_raw = 1'b1;
            if (mem_ready) state_next = ST_WB_MEM;
         end
         ST_MEM_WR: begin
            mem_req_raw  = 1'b1;
            mem_we_raw   = 1'b1;
            addr_sel_raw = 1'b1;
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = ST_FETCH;
            end
         end
         ST_WB_ALU, ST_WB_MEM: begin
            rf_we_raw  = 1'b1;
            wb_sel_raw = (state_reg == ST_WB_MEM) ? WB_MEM_DATA : WB_ALU_RES;
            retire     = 1'b1;
            state_next = ST_FETCH;
         end
         ST_BRANCH: begin
            src_a_raw  = SRC_A_RS1;
            alu_op_raw = ALU_SUB;
            if (!legal) begin
               state_next = ST_TRAP;
            end else begin
               retire     = 1'b1;
               state_next = ST_FETCH;
               if (branch_on_zero == zero) begin
                  pc_we_raw  = 1'b1;
                  pc_src_raw = 1'b1;
               end
            end
         end
         ST_JAL: begin
            rf_we_raw  = 1'b1;
            wb_sel_raw = WB_PC4;
            pc_we_raw  = 1'b1;
            pc_src_raw = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
         end
         ST_TRAP: illegal_raw = 1'b1;
         default: state_next = ST_TRAP;
      endcase
   end

   // Reset squashes every output, abandoning any in-flight memory access
   assign mem_req   = rst_n & mem_req_raw;
   assign mem_we    = rst_n & mem_we_raw;
   assign addr_sel  = rst_n & addr_sel_raw;
   assign ir_we     = rst_n & ir_we_raw;
   assign pc_we     = rst_n & pc_we_raw;
   assign pc_src    = rst_n & pc_src_raw;
   assign rf_we     = rst_n & rf_we_raw;
   assign illegal   = rst_n & illegal_raw;
   assign wb_sel    = rst_n ? wb_sel_raw : '0;
   assign imm_sel   = rst_n ? IMM_SEL_W'(imm_raw) : '0;
   assign alu_src_a = rst_n ? src_a_raw : '0;
   assign alu_src_b = rst_n ? src_b_raw : '0;
   assign alu_op    = rst_n ? alu_op_raw : '0;
   assign instret   = rst_n ? instret_reg : '0;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Self-checking bench: per-instruction expected control traces built from the
// instruction class, with random wait states, zero flags and instruction mix.
module tb_unidad_control_multiciclo;

   localparam logic [6:0] T_R      = 7'b0110011;
   localparam logic [6:0] T_IMM    = 7'b0010011;
   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_SYSTEM = 7'b1110011;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, illegal;
   logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
   logic [2:0]  imm_sel;
   logic [31:0] instret;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_instret = '0;
   logic [18:0] m_all, m_noimm;

   unidad_control_multiciclo #(.IMM_SEL_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .zero      (zero),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .addr_sel  (addr_sel),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_src    (pc_src),
      .rf_we     (rf_we),
      .wb_sel    (wb_sel),
      .imm_sel   (imm_sel),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .illegal   (illegal),
      .instret   (instret)
   );

   wire [18:0] obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we,
                      wb_sel, imm_sel, alu_src_a, alu_src_b, alu_op, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [18:0] cv(input logic mreq, input logic mwe, input logic asel,
                                      input logic irw, input logic pcw, input logic pcs,
                                      input logic rfw, input logic [1:0] wb, input logic [2:0] imm,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic ill);
      return {mreq, mwe, asel, irw, pcw, pcs, rfw, wb, imm, a, b, op, ill};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one clock cycle: drive at negedge, check controls, then check instret after the edge
   task automatic step(input string tag, input logic [18:0] exp, input logic [18:0] msk,
                       input logic rdy, input logic z, input bit ret);
      mem_ready = rdy;
      zero      = z;
      #2;
      check(tag, 32'(obs & msk), 32'(exp & msk));
      @(posedge clk);
      if (ret) model_instret = model_instret + 32'd1;
      #1;
      check({tag, "_instret"}, instret, model_instret);
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'($urandom);
         zero      = 1'($urandom);
         opcode    = 7'($urandom);
         #2;
         check({tag, "_ctl"}, 32'(obs), 32'd0);
         check({tag, "_instret"}, instret, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      rst_n         = 1'b1;
      model_instret = '0;
      $display("txn %s reset released", tag);
   endtask

   task automatic trap_hold(input string tag);
      for (int i = 0; i < 12; i++)
         step({tag, "_trap"}, cv(0,0,0,0,0,0,0,0,0,0,0,0,1), m_all,
              1'($urandom), 1'($urandom), 1'b0);
      do_reset({tag, "_exit"});
   endtask

   task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic z, input int fw, input int mw);
      logic [2:0] imm;
      logic       taken;
      funct7b5 = 1'($urandom);
      for (int i = 0; i < fw; i++) begin
         opcode = 7'($urandom);
         funct3 = 3'($urandom);
         step({tag, "_fetch_wait"}, cv(1,0,0,0,0,0,0,0,0,0,0,0,0), m_all,
              1'b0, 1'($urandom), 1'b0);
      end
      opcode = 7'($urandom);
      step({tag, "_fetch"}, cv(1,0,0,1,1,0,0,0,0,0,0,0,0), m_all, 1'b1, 1'($urandom), 1'b0);
      opcode = opc;
      funct3 = f3;
      if (opc == T_BRANCH)
         step({tag, "_decode"}, cv(0,0,0,0,0,0,0,0,3,0,1,0,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
      else if (opc == T_JAL)
         step({tag, "_decode"}, cv(0,0,0,0,0,0,0,0,5,0,1,0,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
      else
         step({tag, "_decode"}, cv(0,0,0,0,0,0,0,0,0,0,1,0,0), m_noimm, 1'($urandom), 1'($urandom), 1'b0);
      case (opc)
         T_R: begin
            step({tag, "_exec_r"}, cv(0,0,0,0,0,0,0,0,0,1,0,2,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
            step({tag, "_wb_alu"}, cv(0,0,0,0,0,0,1,0,0,0,0,0,0), m_all, 1'($urandom), 1'($urandom), 1'b1);
         end
         T_IMM, T_LUI: begin
            if (opc == T_LUI) begin
               step({tag, "_exec_i"}, cv(0,0,0,0,0,0,0,0,4,2,1,2,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
            end else begin
               imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'd0 : 3'd1;
               step({tag, "_exec_i"}, cv(0,0,0,0,0,0,0,0,imm,1,1,2,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
            end
            step({tag, "_wb_alu"}, cv(0,0,0,0,0,0,1,0,0,0,0,0,0), m_all, 1'($urandom), 1'($urandom), 1'b1);
         end
         T_LOAD: begin
            step({tag, "_addr"}, cv(0,0,0,0,0,0,0,0,1,1,1,0,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i < mw; i++)
               step({tag, "_mem_rd_wait"}, cv(1,0,1,0,0,0,0,0,0,0,0,0,0), m_all, 1'b0, 1'($urandom), 1'b0);
            step({tag, "_mem_rd"}, cv(1,0,1,0,0,0,0,0,0,0,0,0,0), m_all, 1'b1, 1'($urandom), 1'b0);
            step({tag, "_wb_mem"}, cv(0,0,0,0,0,0,1,1,0,0,0,0,0), m_all, 1'($urandom), 1'($urandom), 1'b1);
         end
         T_STORE: begin
            step({tag, "_addr"}, cv(0,0,0,0,0,0,0,0,2,1,1,0,0), m_all, 1'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i < mw; i++)
               step({tag, "_mem_wr_wait"}, cv(1,1,1,0,0,0,0,0,0,0,0,0,0), m_all, 1'b0, 1'($urandom), 1'b0);
            step({tag, "_mem_wr"}, cv(1,1,1,0,0,0,0,0,0,0,0,0,0), m_all, 1'b1, 1'($urandom), 1'b1);
         end
         T_BRANCH: begin
            taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
            if (f3 == 3'b000 || f3 == 3'b001) begin
               step({tag, "_branch"}, cv(0,0,0,0,taken,taken,0,0,0,1,0,1,0), m_all, 1'($urandom), z, 1'b1);
            end else begin
               step({tag, "_branch"}, cv(0,0,0,0,0,0,0,0,0,1,0,1,0), m_all, 1'($urandom), z, 1'b0);
               trap_hold(tag);
            end
         end
         T_JAL: step({tag, "_jal"}, cv(0,0,0,0,1,1,1,2,0,0,0,0,0), m_all, 1'($urandom), 1'($urandom), 1'b1);
         default: trap_hold(tag);
      endcase
      $display("txn %s op=%b f3=%b instret=%0d", tag, opc, f3, model_instret);
   endtask

   initial begin
      logic [6:0] opc;
      logic [2:0] f3;
      m_all     = cv(1,1,1,1,1,1,1,3,7,3,3,3,1);
      m_noimm   = cv(1,1,1,1,1,1,1,3,0,3,3,3,1);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      opcode    = T_IMM;
      funct3    = 3'b000;
      funct7b5  = 1'b0;
      @(negedge clk);
      do_reset("reset");

      run_instr("addi",     T_IMM,    3'b000, 1'b0, 0, 0);
      run_instr("slli",     T_IMM,    3'b001, 1'b0, 0, 0);
      run_instr("srai",     T_IMM,    3'b101, 1'b1, 1, 0);
      run_instr("lui",      T_LUI,    3'b011, 1'b0, 0, 0);
      run_instr("add",      T_R,      3'b000, 1'b1, 0, 0);
      run_instr("lw_wait3", T_LOAD,   3'b010, 1'b0, 0, 3);
      run_instr("sw_wait2", T_STORE,  3'b010, 1'b1, 2, 2);
      run_instr("beq_t",    T_BRANCH, 3'b000, 1'b1, 0, 0);
      run_instr("beq_nt",   T_BRANCH, 3'b000, 1'b0, 0, 0);
      run_instr("bne_t",    T_BRANCH, 3'b001, 1'b0, 0, 0);
      run_instr("bne_nt",   T_BRANCH, 3'b001, 1'b1, 0, 0);
      run_instr("jal",      T_JAL,    3'b000, 1'b0, 1, 0);

      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom);
         case ($urandom_range(0, 6))
            0: opc = T_R;
            1: opc = T_IMM;
            2: opc = T_LUI;
            3: opc = T_LOAD;
            4: opc = T_STORE;
            5: begin opc = T_BRANCH; f3 = {2'b00, 1'($urandom)}; end
            default: opc = T_JAL;
         endcase
         run_instr("rand", opc, f3, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // counter wrap: preload all-ones during a non-retiring fetch wait
      force dut.instret_reg = 32'hFFFF_FFFF;
      model_instret = 32'hFFFF_FFFF;
      step("wrap_hold", cv(1,0,0,0,0,0,0,0,0,0,0,0,0), m_all, 1'b0, 1'b0, 1'b0);
      release dut.instret_reg;
      run_instr("wrap_jal", T_JAL, 3'b000, 1'b0, 0, 0);

      step("rst_fetch_wait", cv(1,0,0,0,0,0,0,0,0,0,0,0,0), m_all, 1'b0, 1'b0, 1'b0);
      do_reset("rst_mid_fetch");
      run_instr("post_rst_addi", T_IMM, 3'b000, 1'b0, 0, 0);

      run_instr("blt_illegal", T_BRANCH, 3'b100, 1'b1, 0, 0);
      run_instr("addi_b", T_IMM, 3'b010, 1'b0, 0, 0);
      run_instr("ecall", T_SYSTEM, 3'b000, 1'b0, 1, 0);
      run_instr("addi_c", T_IMM, 3'b000, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
